// File: rtl/mux4_pkg.sv
// mux4_pkg: select codes and select type shared by the mux4 blocks
package mux4_pkg;
    localparam logic [1:0] SEL_D0 = 2'b00;
    localparam logic [1:0] SEL_D1 = 2'b01;
    localparam logic [1:0] SEL_D2 = 2'b10;
    localparam logic [1:0] SEL_D3 = 2'b11;
    typedef logic [1:0] sel_t;
endpackage

// File: rtl/mux4_comb.sv
// mux4_comb: purely combinational 4:1 selector; unknown select propagates X
module mux4_comb
    import mux4_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  sel_t             sel,
    output logic [WIDTH-1:0] y
);
    // case rather than nested ternaries so an X/Z select yields X instead of a merge
    always_comb begin
        case (sel)
            SEL_D0:  y = d0;
            SEL_D1:  y = d1;
            SEL_D2:  y = d2;
            SEL_D3:  y = d3;
            default: y = {WIDTH{1'bx}};
        endcase
    end
endmodule

// File: rtl/mux4_behav.sv
// mux4_behav: 4:1 selector with one-hot select decode and an enabled, async-reset output register
module mux4_behav
    import mux4_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  sel_t             sel,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             y_vld,
    output logic [3:0]       sel_oh
);
    logic [WIDTH-1:0] y_d;
    logic             vld_d;
    logic             vld_q;
    mux4_comb #(.WIDTH(WIDTH)) u_comb (
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .sel (sel),
        .y   (y)
    );
    assign sel_oh = 4'b0001 << sel;
    assign y_vld  = vld_q;
    always_comb begin
        y_d   = en ? y : y_q;
        vld_d = en | vld_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            y_q   <= y_d;
            vld_q <= vld_d;
        end
    end
endmodule

// File: tb/tb_mux4_behav.sv
// tb_mux4_behav: directed checks of a scalar and an 8-bit mux4_behav
module tb_mux4_behav;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] sel = 2'b00;
    logic       d0 = 1'b0, d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;
    logic       y, y_q, y_vld;
    logic [3:0] sel_oh;
    logic [7:0] e0 = 8'h11, e1 = 8'h22, e2 = 8'h44, e3 = 8'h88;
    logic [7:0] y8, y8_q;
    logic       y8_vld;
    logic [3:0] sel_oh8;
    logic [3:0] pat;
    logic [7:0] exp8 [4] = '{8'h11, 8'h22, 8'h44, 8'h88};
    int         n_tests = 0;
    int         n_fail = 0;

    mux4_behav #(.WIDTH(1)) dut (
        .clk(clk), .rst(rst), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .sel(sel), .en(en), .y(y), .y_q(y_q), .y_vld(y_vld), .sel_oh(sel_oh)
    );
    mux4_behav #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .d0(e0), .d1(e1), .d2(e2), .d3(e3),
        .sel(sel), .en(en), .y(y8), .y_q(y8_q), .y_vld(y8_vld), .sel_oh(sel_oh8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        #1;
        chk("rst_y_q", {7'd0, y_q}, 8'h00);
        chk("rst_y_vld", {7'd0, y_vld}, 8'h00);
        pat = 4'b1001;
        {d3, d2, d1, d0} = pat;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            #10;
            chk($sformatf("y_1001_sel%0d", i), {7'd0, y}, {7'd0, pat[i]});
            chk($sformatf("y8_sel%0d", i), y8, exp8[i]);
        end
        pat = 4'b0110;
        {d3, d2, d1, d0} = pat;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            #10;
            chk($sformatf("y_0110_sel%0d", i), {7'd0, y}, {7'd0, pat[i]});
            chk($sformatf("sel_oh_sel%0d", i), {4'd0, sel_oh}, 8'(4'b0001 << i));
        end
        chk("rst_hold_y_q", {7'd0, y_q}, 8'h00);
        @(negedge clk);
        en = 1'b1;
        sel = 2'b11;
        {d3, d2, d1, d0} = 4'b1000;
        rst = 1'b0;
        #1;
        chk("rel_y_q_pre", {7'd0, y_q}, 8'h00);
        chk("rel_vld_pre", {7'd0, y_vld}, 8'h00);
        @(negedge clk);
        chk("rel_y_q_post", {7'd0, y_q}, 8'h01);
        chk("rel_vld_post", {7'd0, y_vld}, 8'h01);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sel = 2'(i);
            {d3, d2, d1, d0} = 4'b0000;
            #1;
            chk($sformatf("hold_y_%0d", i), {7'd0, y}, 8'h00);
            @(negedge clk);
            chk($sformatf("hold_y_q_%0d", i), {7'd0, y_q}, 8'h01);
            chk($sformatf("hold_vld_%0d", i), {7'd0, y_vld}, 8'h01);
        end
        sel = 2'b10;
        d2 = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk("async_y_q", {7'd0, y_q}, 8'h00);
        chk("async_vld", {7'd0, y_vld}, 8'h00);
        chk("async_y", {7'd0, y}, 8'h01);
        en = 1'b1;
        @(negedge clk);
        chk("rst_over_en_y_q", {7'd0, y_q}, 8'h00);
        chk("rst_over_en_vld", {7'd0, y_vld}, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            @(negedge clk);
            chk($sformatf("w8_y_q_sel%0d", i), y8_q, exp8[i]);
            chk($sformatf("w8_vld_%0d", i), {7'd0, y8_vld}, 8'h01);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
